// File: rtl/crt_timing_pkg.sv
// Shared 640x480@60 timing defaults, derived totals and small helpers
// used by the CRT timing generator.
package crt_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CLK_DIV_DEF  = 4;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Registered sync/blank decode, kept together so reset and update stay in step.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/clk_enable_div.sv
// Free-running divider; en marks the last system clock of each pixel period.
module clk_enable_div #(
  parameter int DIV = 4
) (
  input  logic Clock,
  input  logic Reset,
  output logic en
);

  localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    en    = (div_q == DIV_LAST);
    div_d = en ? '0 : div_q + DIV_ONE;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clock) begin
    if (!Reset) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/crt_timing_gen.sv
// CRT raster timing generator: pixel/line counters with registered sync,
// blanking, pixel-enable and frame markers, all aligned to the counters.
module crt_timing_gen
  import crt_timing_pkg::*;
#(
  parameter int RES_W    = 10,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter bit SYNC_POL = 1'b0,
  parameter int FRAME_W  = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic               hsync,
  output logic               vsync,
  output logic [RES_W-1:0]   xpos,
  output logic [RES_W-1:0]   ypos,
  output logic               video_on,
  output logic               pix_en,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [RES_W-1:0]   H_LAST    = RES_W'(H_TOTAL - 1);
  localparam logic [RES_W-1:0]   V_LAST    = RES_W'(V_TOTAL - 1);
  localparam logic [RES_W-1:0]   H_VIS     = RES_W'(H_ACTIVE);
  localparam logic [RES_W-1:0]   V_VIS     = RES_W'(V_ACTIVE);
  localparam logic [RES_W-1:0]   HS_FIRST  = RES_W'(H_ACTIVE + H_FP);
  localparam logic [RES_W-1:0]   HS_LAST   = RES_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [RES_W-1:0]   VS_FIRST  = RES_W'(V_ACTIVE + V_FP);
  localparam logic [RES_W-1:0]   VS_LAST   = RES_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [RES_W-1:0]   RES_ONE   = RES_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

  logic               tick;
  logic [RES_W-1:0]   x_q, x_d, y_q, y_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               pix_en_q, pix_en_d;
  logic               frame_start_q, frame_start_d;
  sync_t              sync_q, sync_d;
  logic               x_wrap, y_wrap;

  clk_enable_div #(
    .DIV (CLK_DIV)
  ) u_clk_enable_div (
    .Clock (Clock),
    .Reset (Reset),
    .en    (tick)
  );

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    x_wrap        = (x_q == H_LAST);
    y_wrap        = (y_q == V_LAST);
    x_d           = x_q;
    y_d           = y_q;
    frame_d       = frame_q;
    pix_en_d      = tick;
    frame_start_d = 1'b0;

    if (tick) begin
      x_d = x_wrap ? '0 : x_q + RES_ONE;
      if (x_wrap) begin
        y_d = y_wrap ? '0 : y_q + RES_ONE;
        if (y_wrap) begin
          frame_start_d = 1'b1;
          frame_d       = frame_q + FRAME_ONE;
        end
      end
    end

    // Decoding the next counter values keeps sync/blank in the same cycle as xpos/ypos.
    sync_d.hsync    = sync_level((x_d >= HS_FIRST) && (x_d <= HS_LAST), SYNC_POL);
    sync_d.vsync    = sync_level((y_d >= VS_FIRST) && (y_d <= VS_LAST), SYNC_POL);
    sync_d.video_on = (x_d < H_VIS) && (y_d < V_VIS);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_q       <= '0;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_q        <= '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, video_on: 1'b1};
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_q       <= frame_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
      sync_q        <= sync_d;
    end
  end

  assign xpos        = x_q;
  assign ypos        = y_q;
  assign frame_count = frame_q;
  assign pix_en      = pix_en_q;
  assign frame_start = frame_start_q;
  assign hsync       = sync_q.hsync;
  assign vsync       = sync_q.vsync;
  assign video_on    = sync_q.video_on;

endmodule

// File: doc/crt_timing_gen.md
CRT_TIMING_GEN -- requirements
Module: crt_timing_gen

Interface
REQ-001 Parameter RES_W, default 10: width of xpos/ypos and internal counters.
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal front porch, sync and back porch in pixels.
REQ-004 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-005 Parameters V_FP/V_SYNC/V_BP, defaults 10/2/33: vertical front porch, sync and back porch in lines.
REQ-006 Parameter CLK_DIV, default 4: system clocks per pixel (100 MHz / 25 MHz); legal range 1..16.
REQ-007 Parameter SYNC_POL, default 0: active level of hsync/vsync (0 = active-low).
REQ-008 Parameter FRAME_W, default 8: width of frame_count.
REQ-009 Clock  input  1  system clock, 100 MHz.
REQ-010 Reset  input  1  synchronous, active-low reset.
REQ-011 hsync  output  1  horizontal sync, registered.
REQ-012 vsync  output  1  vertical sync, registered.
REQ-013 xpos  output  RES_W  current pixel column, 0..H_TOTAL-1.
REQ-014 ypos  output  RES_W  current line, 0..V_TOTAL-1.
REQ-015 video_on  output  1  high while xpos<H_ACTIVE and ypos<V_ACTIVE.
REQ-016 pix_en  output  1  one-Clock pulse per pixel period.
REQ-017 frame_start  output  1  one-Clock pulse when the counters wrap to (0,0).
REQ-018 frame_count  output  FRAME_W  completed-frame counter; wraps to 0.

Function
REQ-019 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP; the defaults give 800 and 525.
REQ-020 The divider counts 0..CLK_DIV-1 and wraps to 0.
REQ-021 pix_en is high in the Clock cycle where the divider equals CLK_DIV-1.
REQ-022 With CLK_DIV=1, pix_en is constantly high after reset.
REQ-023 xpos advances only on cycles with pix_en; it wraps from H_TOTAL-1 to 0.
REQ-024 ypos advances only when xpos wraps; it wraps from V_TOTAL-1 to 0.
REQ-025 hsync is at its active level exactly while xpos is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751); otherwise it is at the inactive level.
REQ-026 vsync is at its active level exactly while ypos is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491).
REQ-027 hsync, vsync and video_on are registered from next-state counter values, so they are cycle-aligned with xpos/ypos (zero relative latency).
REQ-028 frame_start pulses for one Clock cycle on the pix_en cycle where both counters wrap to (0,0).
REQ-029 frame_count increments on that same cycle and wraps from 2^FRAME_W-1 to 0.
REQ-030 No output changes between pix_en pulses, except pix_en and frame_start falling.

Reset
REQ-031 While Reset=0 at a rising edge of Clock, the following clear: divider, xpos=0, ypos=0, frame_count=0, pix_en=0, frame_start=0.
REQ-032 Under the same condition, video_on=1, and hsync and vsync take the inactive level (!SYNC_POL).
REQ-033 Reset asserted mid-frame overrides all counting in that cycle.
REQ-034 After reset release, the first pix_en occurs CLK_DIV cycles later; no frame_start is issued for the partial frame aborted by reset.

Structure
REQ-035 The shared package crt_timing_pkg holds the default 640x480@60 timing constants, CLK_DIV default and derived totals.
REQ-036 The pixel-enable divider is the sub-module clk_enable_div (parameter DIV; ports Clock, Reset, en).
REQ-037 Sync and blank decode stays inside crt_timing_gen.

Verification
REQ-038 Reset: hold Reset=0 for 5 cycles, release -> xpos=0, ypos=0, hsync=vsync=1, video_on=1; first pix_en exactly 4 cycles after release.
REQ-039 Line timing (defaults): pix_en period = 4 clocks; hsync low for 96 pixels (384 clocks) starting at xpos=656; line period = 3200 clocks; video_on low from xpos=640.
REQ-040 Frame timing: vsync low for 2 lines starting at ypos=490; frame_start period = 1,680,000 clocks; frame_count increments by 1 per frame.
REQ-041 Wrap: run with FRAME_W=2 for 5 frames -> frame_count sequence 1,2,3,0,1.
REQ-042 Mid-frame reset: assert Reset=0 at xpos=300, ypos=200 -> next cycle xpos=0, ypos=0, frame_count=0, frame_start stays 0.
REQ-043 Parameter sweep: CLK_DIV=1 with SYNC_POL=1 -> pix_en constantly high, hsync high for xpos 656..751, line period = 800 clocks.
